// File: rtl/video_pkg.sv
// video_pkg: mode encodings, luma weights and pipeline constants shared by the video filters.
package video_pkg;
    localparam logic [2:0] MODE_COLOUR = 3'd0;
    localparam logic [2:0] MODE_GREEN  = 3'd1;
    localparam logic [2:0] MODE_AMBER  = 3'd2;
    localparam logic [2:0] MODE_WHITE  = 3'd3;
    localparam logic [2:0] MODE_INV    = 3'd4;
    localparam int KR = 54;
    localparam int KG = 183;
    localparam int KB = 19;
    localparam int LUMA_SHIFT = 8;
    localparam int PIPE_LAT = 3;
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic dim;
    } side_t;
    function automatic logic [2:0] map_mode(input logic [2:0] m);
        return (m > MODE_INV) ? MODE_COLOUR : m;
    endfunction
endpackage

// File: rtl/video_luma.sv
// video_luma: two-stage pixel-enable-gated Rec.709 luma (weights sum to 256, so no saturation).
module video_luma
    import video_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [CW-1:0] i_r,
    input  logic [CW-1:0] i_g,
    input  logic [CW-1:0] i_b,
    output logic [CW-1:0] o_y
);
    logic [CW+7:0] r_pr, r_pg, r_pb;
    logic [CW+7:0] w_sum;
    assign w_sum = r_pr + r_pg + r_pb;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr <= '0;
            r_pg <= '0;
            r_pb <= '0;
            o_y  <= '0;
        end else if (ce) begin
            r_pr <= (CW+8)'(KR * i_r);
            r_pg <= (CW+8)'(KG * i_g);
            r_pb <= (CW+8)'(KB * i_b);
            o_y  <= w_sum[LUMA_SHIFT +: CW];
        end
    end
endmodule

// File: rtl/video_mono_filter.sv
// video_mono_filter: frame-latched monochrome recolouring with scanline dimming,
// three enabled cycles of latency for pixels and sideband alike.
module video_mono_filter
    import video_pkg::*;
#(
    parameter int   CW        = 6,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic          clk_vga,
    input  logic          rst,
    input  logic          ce_pix,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          blank_in,
    input  logic [2:0]    mode_in,
    input  logic          scan_en_in,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          blank_out,
    output logic [2:0]    mode_active
);
    localparam side_t SIDE_RST = '{hs: SYNC_IDLE, vs: SYNC_IDLE, blank: 1'b1, dim: 1'b0};
    localparam logic [CW-1:0] MAXV = '1;
    logic r_hs_d, r_vs_d, r_scan, r_par;
    side_t r_side [PIPE_LAT-1];
    logic [3*CW-1:0] r_raw [PIPE_LAT-1];
    logic w_hs_edge, w_vs_edge;
    logic [CW-1:0] w_y, w_inv, w_r, w_g, w_b, w_rr, w_rg, w_rb;
    side_t w_s;
    assign w_hs_edge = ce_pix && (hs_in != SYNC_IDLE) && (r_hs_d == SYNC_IDLE);
    assign w_vs_edge = ce_pix && (vs_in != SYNC_IDLE) && (r_vs_d == SYNC_IDLE);
    video_luma #(.CW(CW)) u_luma (
        .clk(clk_vga), .rst(rst), .ce(ce_pix),
        .i_r(r_in), .i_g(g_in), .i_b(b_in), .o_y(w_y)
    );
    assign w_s = r_side[PIPE_LAT-2];
    assign {w_rr, w_rg, w_rb} = r_raw[PIPE_LAT-2];
    assign w_inv = MAXV - w_y;
    assign w_r = (mode_active == MODE_GREEN) ? '0 :
                 (mode_active == MODE_AMBER || mode_active == MODE_WHITE) ? w_y :
                 (mode_active == MODE_INV) ? w_inv : w_rr;
    assign w_g = (mode_active == MODE_GREEN || mode_active == MODE_WHITE) ? w_y :
                 (mode_active == MODE_AMBER) ? (w_y >> 1) :
                 (mode_active == MODE_INV) ? w_inv : w_rg;
    assign w_b = (mode_active == MODE_GREEN || mode_active == MODE_AMBER) ? '0 :
                 (mode_active == MODE_WHITE) ? w_y :
                 (mode_active == MODE_INV) ? w_inv : w_rb;
    // blank overrides both the mode mux and the scanline dim
    function automatic logic [CW-1:0] finish(input logic [CW-1:0] x, input side_t s);
        return s.blank ? '0 : s.dim ? (x >> 1) : x;
    endfunction
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_hs_d      <= SYNC_IDLE;
            r_vs_d      <= SYNC_IDLE;
            r_scan      <= 1'b0;
            r_par       <= 1'b0;
            mode_active <= MODE_COLOUR;
            for (int i = 0; i < PIPE_LAT-1; i++) begin
                r_side[i] <= SIDE_RST;
                r_raw[i]  <= '0;
            end
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            hs_out    <= SYNC_IDLE;
            vs_out    <= SYNC_IDLE;
            blank_out <= 1'b1;
        end else if (ce_pix) begin
            r_hs_d <= hs_in;
            r_vs_d <= vs_in;
            if (w_vs_edge) begin
                mode_active <= map_mode(mode_in);
                r_scan      <= scan_en_in;
                r_par       <= 1'b0;
            end else if (w_hs_edge) begin
                r_par <= ~r_par;
            end
            r_side[0] <= '{hs: hs_in, vs: vs_in, blank: blank_in, dim: r_par & r_scan};
            r_raw[0]  <= {r_in, g_in, b_in};
            for (int i = 1; i < PIPE_LAT-1; i++) begin
                r_side[i] <= r_side[i-1];
                r_raw[i]  <= r_raw[i-1];
            end
            r_out     <= finish(w_r, w_s);
            g_out     <= finish(w_g, w_s);
            b_out     <= finish(w_b, w_s);
            hs_out    <= w_s.hs;
            vs_out    <= w_s.vs;
            blank_out <= w_s.blank;
        end
    end
endmodule
